// File: rtl/spi_rx.sv
// SPI receive deserializer: oversamples sclk/rxd in the clk domain, recovers MSB-first words
// and presents them on an AXI-Stream master with a single-word output register.
module spi_rx #(
  parameter int DATA_WIDTH   = 8,
  parameter int SPI_MODE     = 0,
  parameter int IDLE_TIMEOUT = 256
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  sclk,
  input  logic                  rxd,
  output logic [DATA_WIDTH-1:0] m_axis_tdata,
  output logic                  m_axis_tvalid,
  input  logic                  m_axis_tready,
  output logic                  busy,
  output logic                  overrun,
  output logic                  frame_err,
  output logic                  dbg_state
);

  // Stream handshake: a word transfers on the clk edge where m_axis_tvalid && m_axis_tready;
  // tvalid never drops and tdata never changes while tvalid && !tready.

  localparam logic CPOL = logic'(SPI_MODE >= 2);
  localparam logic CPHA = logic'(SPI_MODE == 1 || SPI_MODE == 3);
  localparam int   CNT_W = $clog2(DATA_WIDTH + 1);
  localparam int   TO_W  = $clog2(IDLE_TIMEOUT);
  localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(DATA_WIDTH - 1);
  localparam logic [TO_W-1:0]  TO_LAST  = TO_W'(IDLE_TIMEOUT - 1);

  typedef enum logic {
    S_IDLE = 1'b0,
    S_RECV = 1'b1
  } state_t;

  state_t state, state_next;

  logic                  sclk_s1, sclk_s2, sclk_prev;
  logic                  rxd_s1, rxd_s2;
  logic                  sample_edge;
  logic                  word_done;
  logic                  timeout;
  logic [DATA_WIDTH-1:0] shift_reg;
  logic [DATA_WIDTH:0]   word_full;
  logic [DATA_WIDTH-1:0] word;
  logic [CNT_W-1:0]      bit_cnt;
  logic [TO_W-1:0]       to_cnt;

  // Synchronisers idle at CPOL so reset release never looks like a clock edge.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sclk_s1   <= CPOL;
      sclk_s2   <= CPOL;
      sclk_prev <= CPOL;
      rxd_s1    <= CPOL;
      rxd_s2    <= CPOL;
    end else begin
      sclk_s1   <= sclk;
      sclk_s2   <= sclk_s1;
      sclk_prev <= sclk_s2;
      rxd_s1    <= rxd;
      rxd_s2    <= rxd_s1;
    end
  end

  // Modes 0/3 sample on the rising edge, modes 1/2 on the falling edge.
  assign sample_edge = (CPOL == CPHA) ? (sclk_s2 & ~sclk_prev) : (~sclk_s2 & sclk_prev);

  // Appending the new bit and dropping the oldest also covers DATA_WIDTH == 1.
  assign word_full = {shift_reg, rxd_s2};
  assign word      = word_full[DATA_WIDTH-1:0];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= S_IDLE;
    else     state <= state_next;
  end

  always_comb begin
    state_next = state;
    word_done  = 1'b0;
    timeout    = 1'b0;
    case (state)
      S_IDLE: begin
        if (sample_edge) begin
          if (DATA_WIDTH == 1) word_done  = 1'b1;
          else                 state_next = S_RECV;
        end
      end
      S_RECV: begin
        if (sample_edge) begin
          if (bit_cnt == LAST_BIT) begin
            word_done  = 1'b1;
            state_next = S_IDLE;
          end
        end else if (to_cnt == TO_LAST) begin
          timeout    = 1'b1;
          state_next = S_IDLE;
        end
      end
      default: state_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      shift_reg <= '0;
      bit_cnt   <= '0;
    end else if (timeout) begin
      shift_reg <= '0;
      bit_cnt   <= '0;
    end else if (sample_edge) begin
      shift_reg <= word;
      bit_cnt   <= word_done ? '0 : bit_cnt + CNT_W'(1);
    end
  end

  // Cleared on firing as well, so the counter never reaches IDLE_TIMEOUT and never wraps.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      to_cnt <= '0;
    end else if (state == S_IDLE || sample_edge || timeout) begin
      to_cnt <= '0;
    end else begin
      to_cnt <= to_cnt + TO_W'(1);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      m_axis_tdata  <= '0;
      m_axis_tvalid <= 1'b0;
      overrun       <= 1'b0;
      frame_err     <= 1'b0;
    end else begin
      if (word_done && (!m_axis_tvalid || m_axis_tready)) begin
        m_axis_tdata  <= word;
        m_axis_tvalid <= 1'b1;
      end else if (m_axis_tvalid && m_axis_tready) begin
        m_axis_tvalid <= 1'b0;
      end
      overrun   <= word_done && m_axis_tvalid && !m_axis_tready;
      frame_err <= timeout;
    end
  end

  assign busy      = (state == S_RECV);
  assign dbg_state = state;

endmodule

// File: tb/tb_spi_rx.sv
// Bench for spi_rx: one receiver per SPI mode, a task-based SPI master model and a
// scoreboard queue checked against every stream beat.
module tb_spi_rx;

  localparam int P = 8;  // sclk half-period in clk cycles

  logic       clk;
  logic       rst;
  logic [3:0] sclk_v;
  logic [3:0] rxd_v;
  logic [3:0] tready_v;
  logic [3:0] tvalid_v;
  logic [3:0] busy_v;
  logic [3:0] ovr_v;
  logic [3:0] fe_v;
  logic [3:0] dbg_v;
  logic [7:0] tdata_w [4];

  logic [7:0] exp_q[$];
  int         errors;
  int         checks;
  int         ovr_cnt;
  int         fe_cnt;

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  spi_rx #(.DATA_WIDTH(8), .SPI_MODE(0), .IDLE_TIMEOUT(256)) u_m0 (
    .clk(clk), .rst(rst), .sclk(sclk_v[0]), .rxd(rxd_v[0]),
    .m_axis_tdata(tdata_w[0]), .m_axis_tvalid(tvalid_v[0]), .m_axis_tready(tready_v[0]),
    .busy(busy_v[0]), .overrun(ovr_v[0]), .frame_err(fe_v[0]), .dbg_state(dbg_v[0]));
  spi_rx #(.DATA_WIDTH(8), .SPI_MODE(1), .IDLE_TIMEOUT(256)) u_m1 (
    .clk(clk), .rst(rst), .sclk(sclk_v[1]), .rxd(rxd_v[1]),
    .m_axis_tdata(tdata_w[1]), .m_axis_tvalid(tvalid_v[1]), .m_axis_tready(tready_v[1]),
    .busy(busy_v[1]), .overrun(ovr_v[1]), .frame_err(fe_v[1]), .dbg_state(dbg_v[1]));
  spi_rx #(.DATA_WIDTH(8), .SPI_MODE(2), .IDLE_TIMEOUT(256)) u_m2 (
    .clk(clk), .rst(rst), .sclk(sclk_v[2]), .rxd(rxd_v[2]),
    .m_axis_tdata(tdata_w[2]), .m_axis_tvalid(tvalid_v[2]), .m_axis_tready(tready_v[2]),
    .busy(busy_v[2]), .overrun(ovr_v[2]), .frame_err(fe_v[2]), .dbg_state(dbg_v[2]));
  spi_rx #(.DATA_WIDTH(8), .SPI_MODE(3), .IDLE_TIMEOUT(256)) u_m3 (
    .clk(clk), .rst(rst), .sclk(sclk_v[3]), .rxd(rxd_v[3]),
    .m_axis_tdata(tdata_w[3]), .m_axis_tvalid(tvalid_v[3]), .m_axis_tready(tready_v[3]),
    .busy(busy_v[3]), .overrun(ovr_v[3]), .frame_err(fe_v[3]), .dbg_state(dbg_v[3]));

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // driver tasks: inputs change 1 time unit after the rising edge
  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  // rdy_pulse raises tready of receiver 0 only for the clk edge that completes the word
  task automatic send(input int m, input logic [7:0] val, input int nbits,
                      input bit rdy_pulse, input bit chk_busy);
    logic cpol, cpha;
    cpol = (m >= 2);
    cpha = (m % 2 == 1);
    for (int b = 0; b < nbits; b++) begin
      if (!cpha) begin
        rxd_v[m] = val[7-b];
        tick(P);
        sclk_v[m] = ~cpol;
        if (rdy_pulse && b == 7) begin
          tick(2);
          tready_v[0] = 1'b1;
          tick(1);
          tready_v[0] = 1'b0;
          tick(P - 3);
        end else begin
          tick(P);
        end
        sclk_v[m] = cpol;
        tick(P);
      end else begin
        sclk_v[m] = ~cpol;
        rxd_v[m]  = val[7-b];
        tick(P);
        sclk_v[m] = cpol;
        tick(P);
      end
      if (chk_busy) check("busy_after_bit", busy_v[m], (b != 7));
    end
  endtask

  task automatic wait_drain(input string tag);
    int n;
    n = 0;
    while (exp_q.size() != 0 && n < 200) begin
      tick(1);
      n++;
    end
    check(tag, exp_q.size(), 0);
  endtask

  // scoreboard: every accepted beat must match the head of the expected queue
  always @(negedge clk) begin
    if (!rst) begin
      for (int i = 0; i < 4; i++) begin
        if (tvalid_v[i] && tready_v[i]) begin
          check("beat_expected", (exp_q.size() != 0), 1);
          if (exp_q.size() != 0) check("beat_tdata", tdata_w[i], exp_q.pop_front());
        end
      end
      if (ovr_v[0]) ovr_cnt++;
      if (fe_v[0])  fe_cnt++;
    end
  end

  initial begin
    int ovr_snap, fe_snap;
    errors   = 0;
    checks   = 0;
    ovr_cnt  = 0;
    fe_cnt   = 0;
    rst      = 1'b1;
    sclk_v   = 4'b1100;
    rxd_v    = 4'b0000;
    tready_v = 4'b1111;
    tick(3);
    check("reset_tvalid", tvalid_v, 4'b0000);
    check("reset_busy", busy_v, 4'b0000);
    check("reset_pulses", {ovr_v, fe_v}, 8'h00);
    check("reset_tdata0", tdata_w[0], 8'h00);
    rst = 1'b0;
    tick(4);

    // mode 0 single word, busy tracked bit by bit
    exp_q.push_back(8'hA5);
    send(0, 8'hA5, 8, 1'b0, 1'b1);
    wait_drain("drain_a5");
    tick(2);
    check("a5_tvalid_low", tvalid_v[0], 1'b0);

    // other modes
    for (int m = 1; m < 4; m++) begin
      exp_q.push_back(8'h3C);
      send(m, 8'h3C, 8, 1'b0, 1'b0);
      wait_drain("drain_3c");
      check("mode_busy_idle", busy_v[m], 1'b0);
    end

    // backpressure: second word dropped
    tready_v[0] = 1'b0;
    ovr_snap = ovr_cnt;
    send(0, 8'h11, 8, 1'b0, 1'b0);
    send(0, 8'h22, 8, 1'b0, 1'b0);
    check("ovr_tdata_hold", tdata_w[0], 8'h11);
    check("ovr_tvalid_hold", tvalid_v[0], 1'b1);
    check("ovr_pulse_count", ovr_cnt - ovr_snap, 1);
    exp_q.push_back(8'h11);
    tready_v[0] = 1'b1;
    tick(2);
    check("ovr_drained", tvalid_v[0], 1'b0);
    check("ovr_queue_empty", exp_q.size(), 0);

    // idle timeout on a partial word
    fe_snap = fe_cnt;
    send(0, 8'hE0, 3, 1'b0, 1'b0);
    check("partial_busy", busy_v[0], 1'b1);
    tick(230);
    check("partial_busy_late", busy_v[0], 1'b1);
    check("no_early_frame_err", fe_cnt - fe_snap, 0);
    tick(30);
    check("timeout_busy", busy_v[0], 1'b0);
    check("frame_err_count", fe_cnt - fe_snap, 1);
    exp_q.push_back(8'h5A);
    send(0, 8'h5A, 8, 1'b0, 1'b0);
    wait_drain("drain_5a");

    // transfer and completion in the same cycle
    tready_v[0] = 1'b0;
    ovr_snap = ovr_cnt;
    send(0, 8'h01, 8, 1'b0, 1'b0);
    check("hold_01_tdata", tdata_w[0], 8'h01);
    check("hold_01_tvalid", tvalid_v[0], 1'b1);
    exp_q.push_back(8'h01);
    exp_q.push_back(8'h02);
    send(0, 8'h02, 8, 1'b1, 1'b0);
    check("same_cycle_no_ovr", ovr_cnt - ovr_snap, 0);
    check("same_cycle_tvalid", tvalid_v[0], 1'b1);
    check("same_cycle_tdata", tdata_w[0], 8'h02);
    check("same_cycle_popped", exp_q.size(), 1);
    tready_v[0] = 1'b1;
    wait_drain("drain_02");

    // reset in the middle of a word
    fe_snap = fe_cnt;
    send(0, 8'hFF, 4, 1'b0, 1'b0);
    check("pre_rst_busy", busy_v[0], 1'b1);
    rst = 1'b1;
    #1;
    check("rst_async_busy", busy_v[0], 1'b0);
    check("rst_async_outs", {tvalid_v[0], ovr_v[0], fe_v[0]}, 3'b000);
    check("rst_async_tdata", tdata_w[0], 8'h00);
    tick(3);
    rst = 1'b0;
    tick(3);
    exp_q.push_back(8'h81);
    send(0, 8'h81, 8, 1'b0, 1'b0);
    wait_drain("drain_81");
    check("rst_no_frame_err", fe_cnt - fe_snap, 0);

    tick(5);
    check("final_queue_empty", exp_q.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
